ce_pulse_gen: RTL and testbench



---
 rtl/ce_pulse_gen_pkg.sv | 14 +
 rtl/ce_sync2.sv | 21 ++
 rtl/ce_pulse_gen.sv | 126 ++++++++++++
 tb/tb_ce_pulse_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ce_pulse_gen_pkg.sv
// Shared types and defaults for the clock-enable pulse generator.
package ce_pulse_gen_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int BURST_W_DEF = 8;
  localparam int DIV_MIN     = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ce_sync2.sv
// Two-flop synchronizer for a single level control bit; output cleared by rst_n.
module ce_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ce_pulse_gen.sv
// Programmable one-cycle clock-enable pulse generator (continuous or burst) for a downstream DFF en.
// Define CE_PULSE_GEN_SYNC_IN_EN to pass start/stop through two-flop synchronizers (+2 cycles control latency).
module ce_pulse_gen
  import ce_pulse_gen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  output logic               en_out,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_cnt
);

  logic start_s;
  logic stop_s;

`ifdef CE_PULSE_GEN_SYNC_IN_EN
  ce_sync2 u_sync_start (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (start),
    .q     (start_s)
  );

  ce_sync2 u_sync_stop (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (stop),
    .q     (stop_s)
  );
`else
  assign start_s = start;
  assign stop_s  = stop;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] pcnt_d;
  logic               en_d;
  logic               done_d;
  logic [CNT_W-1:0]   div_in_eff;
  logic               burst_hit;

  // A divide ratio of 0 behaves as 1 so the counter always has a valid reload.
  assign div_in_eff = (div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : div;

  // Checked one cycle after the terminal pulse so it still gets its full en cycle.
  assign burst_hit = (burst_q != '0) && (pulse_cnt == burst_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    burst_d = burst_q;
    pcnt_d  = pulse_cnt;
    en_d    = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_s && !stop_s) begin
          state_d = RUN;
          div_d   = div_in_eff;
          burst_d = burst_len;
          cnt_d   = div_in_eff - CNT_W'(1);
          pcnt_d  = '0;
        end
      end

      RUN: begin
        if (stop_s) begin
          state_d = IDLE;
        end else if (burst_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          en_d   = 1'b1;
          cnt_d  = div_q - CNT_W'(1);
          pcnt_d = pulse_cnt + BURST_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      burst_q   <= '0;
      pulse_cnt <= '0;
      en_out    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      burst_q   <= burst_d;
      pulse_cnt <= pcnt_d;
      en_out    <= en_d;
      done      <= done_d;
      busy      <= (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_ce_pulse_gen.sv
// Directed bench for ce_pulse_gen with an arithmetic reference model checked every cycle.
`timescale 1ns/1ps
module tb_ce_pulse_gen;

  localparam int CW = 16;
  localparam int BW = 4;
`ifdef CE_PULSE_GEN_SYNC_IN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] div = '0;
  logic [BW-1:0] burst_len = '0;
  logic          en_out;
  logic          busy;
  logic          done;
  logic [BW-1:0] pulse_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ce_pulse_gen #(.CNT_W(CW), .BURST_W(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .div       (div),
    .burst_len (burst_len),
    .en_out    (en_out),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs derived from elapsed edges since the accepted start.
  int            m_mode = 0;   // 0 idle, 1 run, 2 done
  int            m_n = 0;
  int            m_k = 0;
  int            m_d = 1;
  int            m_b = 0;
  int            e;
  bit            m_en = 0, m_busy = 0, m_done = 0;
  logic [BW-1:0] m_cnt = '0;
  bit [1:0]      sh_start = '0, sh_stop = '0;
  bit            s_start, s_stop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_en = 0; m_busy = 0; m_done = 0; m_cnt = '0;
      sh_start = '0; sh_stop = '0;
    end else begin
      s_start  = (LAT == 2) ? sh_start[1] : start;
      s_stop   = (LAT == 2) ? sh_stop[1]  : stop;
      sh_start = {sh_start[0], start};
      sh_stop  = {sh_stop[0], stop};
      m_en = 0;
      m_done = 0;
      case (m_mode)
        0: if (s_start && !s_stop) begin
             m_mode = 1; m_k = m_n; m_d = (div == 0) ? 1 : int'(div);
             m_b = int'(burst_len); m_cnt = '0;
           end
        1: begin
             e = m_n - m_k;
             if (s_stop) m_mode = 0;
             else if (m_b != 0 && e == m_b * m_d + 1) begin
               m_mode = 2; m_done = 1;
             end else begin
               m_en  = ((e % m_d) == 0);
               m_cnt = BW'((e / m_d) % (1 << BW));
             end
           end
        default: m_mode = 0;
      endcase
      m_busy = (m_mode == 1);
      m_n++;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_en_out", en_out, m_en);
    chk("model_busy", busy, m_busy);
    chk("model_done", done, m_done);
    chk("model_pulse_cnt", pulse_cnt, m_cnt);
  end

  // Per-test edge logs; edge 0 is the edge that samples the start request.
  int            ev;
  logic [31:0]   en_m, dn_m, by_m;
  logic [BW-1:0] cnt_log [0:31];

  task automatic arm();
    ev = -1; en_m = '0; dn_m = '0; by_m = '0;
    for (int i = 0; i < 32; i++) cnt_log[i] = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    ev++;
    if (ev >= 0 && ev < 32) begin
      en_m[ev] = en_out; dn_m[ev] = done; by_m[ev] = busy; cnt_log[ev] = pulse_cnt;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_en_out", en_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pulse_cnt", pulse_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) step();

    // Reset asserted mid-run while a pulse is on the output.
    div = 3; burst_len = 0; arm();
    start = 1; step(); start = 0;
    while (ev < 6 + LAT) step();
    chk("rstmid_pre_en", en_out, 1);
    chk("rstmid_pre_cnt", pulse_cnt, 2);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rstmid_en", en_out, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_cnt", pulse_cnt, 0);
    chk("rstmid_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    arm(); repeat (6) step();
    chk("rstmid_idle_busy", by_m, 0);
    chk("rstmid_idle_done", dn_m, 0);

    // Basic burst, with a start request landing while in DONE.
    div = 4; burst_len = 3; arm();
    start = 1; step(); start = 0;
    while (ev < 13) step();
    start = 1; step(); start = 0;
    while (ev < 20) step();
    chk("burst_en", en_m, 32'h0000_1110 << LAT);
    chk("burst_done", dn_m, 32'h0000_2000 << LAT);
    chk("burst_busy", by_m, 32'h0000_1FFF << LAT);
    chk("burst_cnt", pulse_cnt, 3);

    // div of 0 and 1 both give back-to-back pulses.
    for (int d = 0; d < 2; d++) begin
      div = CW'(d); burst_len = 5; arm();
      start = 1; step(); start = 0;
      while (ev < 12) step();
      chk($sformatf("div%0d_en", d), en_m, 32'h0000_003E << LAT);
      chk($sformatf("div%0d_done", d), dn_m, 32'h0000_0040 << LAT);
      chk($sformatf("div%0d_busy", d), by_m, 32'h0000_003F << LAT);
      chk($sformatf("div%0d_cnt", d), pulse_cnt, 5);
    end

    // Abort on a terminal count, then start+stop together while idle.
    div = 2; burst_len = 10; arm();
    start = 1; step(); start = 0;
    while (ev < 7) step();
    stop = 1;
    while (ev < 10) step();
    start = 1;
    while (ev < 12) step();
    start = 0; stop = 0;
    while (ev < 20) step();
    chk("abort_en", en_m, 32'h0000_0054 << LAT);
    chk("abort_done", dn_m, 0);
    chk("abort_busy", by_m, 32'h0000_00FF << LAT);
    chk("abort_cnt", pulse_cnt, 3);

    // Continuous mode: counter wraps, start during run ignored.
    div = 1; burst_len = 0; arm();
    start = 1; step(); start = 0;
    while (ev < 5) step();
    start = 1;
    while (ev < 7) step();
    start = 0;
    while (ev < 20 + LAT) step();
    chk("cont_en", en_m, 32'h000F_FFFF << (1 + LAT));
    chk("cont_done", dn_m, 0);
    chk("cont_cnt15", cnt_log[15 + LAT], 15);
    chk("cont_wrap0", cnt_log[16 + LAT], 0);
    chk("cont_cnt20", cnt_log[20 + LAT], 4);
    stop = 1;
    repeat (LAT + 2) step();
    stop = 0;
    step();
    chk("cont_stopped_busy", busy, 0);
    chk("cont_stopped_en", en_out, 0);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
